// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one external combinational ALU between two requesters.
// Optional per-requester grant counters are enabled with `define ALU_ARB_GRANT_CNT_EN.
module alu_share_arb #(
  parameter int W    = 5,
  parameter int OPW  = 4,
  parameter int CNTW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_b1,
  input  logic [OPW-1:0] req_s0,
  input  logic [OPW-1:0] req_s1,
  output logic [1:0]     req_ready,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_s,
  input  logic [W-1:0]   alu_y,
  output logic           rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_id,
  input  logic           rsp_ready,
  output logic           busy
`ifdef ALU_ARB_GRANT_CNT_EN
  ,
  input  logic           cnt_clr,
  output logic [CNTW-1:0] grant_cnt0,
  output logic [CNTW-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       id_p0;
  logic [1:0] grant;
  logic       win;
  logic       hs;

  // On a conflict the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    win = grant[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    hs        = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = grant;
        hs        = |(req_valid & grant);
        if (hs) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: winner's operands registered onto the ALU at the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      id_p0      <= 1'b0;
      last_grant <= 1'b1;
    end else if (hs) begin
      alu_a      <= win ? req_a1 : req_a0;
      alu_b      <= win ? req_b1 : req_b0;
      alu_s      <= win ? req_s1 : req_s0;
      id_p0      <= win;
      last_grant <= win;
    end
  end

  // Stage p1: ALU result captured after one settle cycle and held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_y;
      rsp_id    <= id_p0;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_GRANT_CNT_EN
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (cnt_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (hs) begin
      if (win) begin
        grant_cnt1 <= sat_inc(grant_cnt1);
      end else begin
        grant_cnt0 <= sat_inc(grant_cnt0);
      end
    end
  end
`else
  logic unused_cntw;
  assign unused_cntw = ^CNTW;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: transaction-level round-robin model with an adder ALU stub.
// Counter checks are compiled in when ALU_ARB_GRANT_CNT_EN is defined.
module tb_alu_share_arb;
  localparam int W = 5, OPW = 4, CNTW = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [W-1:0]   req_a0, req_a1, req_b0, req_b1;
  logic [OPW-1:0] req_s0, req_s1;
  logic [1:0]     req_ready;
  logic [W-1:0]   alu_a, alu_b, alu_y;
  logic [OPW-1:0] alu_s;
  logic           rsp_valid, rsp_id, rsp_ready, busy;
  logic [W-1:0]   rsp_data;
`ifdef ALU_ARB_GRANT_CNT_EN
  logic            cnt_clr;
  logic [CNTW-1:0] grant_cnt0, grant_cnt1;
`endif

  alu_share_arb #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_s0(req_s0), .req_s1(req_s1), .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
`ifdef ALU_ARB_GRANT_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  assign alu_y = alu_a + alu_b;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int id;
    int data;
    int s;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  int         glog_id[$];
  int         glog_cyc[$];
  bit         model_free = 1'b1;
  bit         m_last = 1'b1;
  logic [1:0] acc_mask = 2'b00;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Who should be accepted: a lone requester, or on conflict the one that did not go last.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return (last == 1'b1) ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Predictor: one operation in flight at a time; arbiter is free once the previous response is taken.
  always @(negedge clk) begin : pred
    logic [1:0] want;
    exp_t e;
    if (!rst_n) begin
      model_free = 1'b1;
      m_last     = 1'b1;
      acc_mask   = 2'b00;
      sb.delete();
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_data", int'(rsp_data), 0);
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_alu_a", int'(alu_a), 0);
      check("rst_alu_b", int'(alu_b), 0);
      check("rst_alu_s", int'(alu_s), 0);
      check("rst_busy", int'(busy), 0);
    end else begin
      want = model_free ? rr_pick(req_valid, m_last) : 2'b00;
      check("req_ready", int'(req_ready), int'(want));
      check("busy", int'(busy), model_free ? 0 : 1);
      acc_mask = want;
      if ((req_valid & req_ready) != 2'b00) begin
        glog_id.push_back(int'(req_ready[1]));
        glog_cyc.push_back(cyc);
      end
      if (want != 2'b00) begin
        e.id   = int'(want[1]);
        e.data = want[1] ? (int'(req_a1) + int'(req_b1)) % 32 : (int'(req_a0) + int'(req_b0)) % 32;
        e.s    = want[1] ? int'(req_s1) : int'(req_s0);
        e.cyc  = cyc;
        sb.push_back(e);
        m_last     = want[1];
        model_free = 1'b0;
      end else if (!model_free && rsp_valid && rsp_ready) begin
        model_free = 1'b1;
      end
    end
  end

  // Monitor: pops an expectation on each new response and checks holds under backpressure.
  bit         hold = 1'b0;
  logic [W-1:0] hdata;
  logic       hid;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      hold = 1'b0;
    end else if (rsp_valid) begin
      if (hold) begin
        check("hold_data", int'(rsp_data), int'(hdata));
        check("hold_id", int'(rsp_id), int'(hid));
      end else if (sb.size() == 0) begin
        check("rsp_valid_unexpected", int'(rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", int'(rsp_data), e.data);
        check("rsp_id", int'(rsp_id), e.id);
        check("alu_s", int'(alu_s), e.s);
        check("latency", cyc - e.cyc, 2);
      end
      hold  = !rsp_ready;
      hdata = rsp_data;
      hid   = rsp_id;
    end else begin
      if (hold) check("rsp_dropped_early", int'(rsp_valid), 1);
      hold = 1'b0;
      if (sb.size() > 0 && (cyc - sb[0].cyc) >= 2) begin
        check("rsp_missing", int'(rsp_valid), 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0;
    req_valid = 2'b00;
    {req_a0, req_a1, req_b0, req_b1} = '0;
    {req_s0, req_s1} = '0;
    rsp_ready = 1'b1;
`ifdef ALU_ARB_GRANT_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy_after_reset", int'(busy), 0);

    // Single request from requester 0
    req_a0 = 5'b10101; req_b0 = 5'b01100; req_s0 = 4'b1101;
    req_valid = 2'b01;
    @(negedge clk);
    check("single_req_ready", int'(req_ready), 1);
    step();
    check("single_alu_s", int'(alu_s), 13);
    step();
    check("single_rsp_valid", int'(rsp_valid), 1);
    check("single_rsp_data", int'(rsp_data), 1);
    check("single_rsp_id", int'(rsp_id), 0);
    step();
    check("single_busy_drop", int'(busy), 0);

    // Conflict and fairness
    do_reset();
    glog_id.delete(); glog_cyc.delete();
    req_a0 = 5'd1; req_b0 = 5'd2; req_s0 = 4'd0;
    req_a1 = 5'd3; req_b1 = 5'd4; req_s1 = 4'd5;
    req_valid = 2'b11;
    for (int k = 0; k < 12; k++) begin
      step();
      req_valid = 2'b11;
    end
    req_valid = 2'b00;
    repeat (4) step();
    check("fair_grant_count", (glog_id.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4 && k < glog_id.size(); k++) begin
      check("fair_order", glog_id[k], k % 2);
      if (k > 0) check("fair_interval", glog_cyc[k] - glog_cyc[k-1], 3);
    end

    // Backpressure with a pending request from requester 1
    do_reset();
    req_a0 = 5'd7; req_b0 = 5'd8; req_s0 = 4'd2;
    req_a1 = 5'd9; req_b1 = 5'd1; req_s1 = 4'd3;
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    step();
    req_valid = req_valid | 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else step();
    end
    check("bp_rsp_seen", int'(rsp_valid), 1);
    repeat (5) begin
      step();
      check("bp_rsp_held", int'(rsp_valid), 1);
      check("bp_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_rsp_fall", int'(rsp_valid), 0);
    check("bp_pending_ready", int'(req_ready), 2);
    step();
    check("bp_pending_taken", int'(busy), 1);
    repeat (4) step();

    // Reset during EXEC discards the operation
    do_reset();
    req_a0 = 5'd10; req_b0 = 5'd5; req_s0 = 4'd1;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      check("midrst_no_rsp", int'(rsp_valid), 0);
    end
    glog_id.delete(); glog_cyc.delete();
    req_a1 = 5'd2; req_b1 = 5'd2;
    req_valid = 2'b11;
    step();
    check("midrst_first_winner", (glog_id.size() > 0) ? glog_id[glog_id.size()-1] : -1, 0);
    repeat (8) step();

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          if (i == 0) begin
            req_a0 = W'($urandom); req_b0 = W'($urandom); req_s0 = OPW'($urandom);
          end else begin
            req_a1 = W'($urandom); req_b1 = W'($urandom); req_s1 = OPW'($urandom);
          end
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 40 && (req_valid != 2'b00 || busy); k++) step();
    check("random_drained", int'(busy), 0);

`ifdef ALU_ARB_GRANT_CNT_EN
    do_reset();
    req_a0 = 5'd1; req_b0 = 5'd1; req_s0 = 4'd0;
    n = 0;
    for (int k = 0; k < 2000 && n < 300; k++) begin
      req_valid = 2'b01;
      @(negedge clk);
      if (req_ready[0]) n++;
      step();
    end
    req_valid = 2'b00;
    repeat (4) step();
    check("cnt0_saturated", int'(grant_cnt0), 255);
    check("cnt1_zero", int'(grant_cnt1), 0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt0_cleared", int'(grant_cnt0), 0);
    check("cnt1_cleared", int'(grant_cnt1), 0);
`else
    n = 0;
    if (n != 0) seen = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
